uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Parameter OVS, default 16, oversample ticks per bit.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 btnCpuReset  input  1  asynchronous, active-low reset.
REQ-006 RsRx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 rx_data  output  8  received byte, stable while rx_valid=1.
REQ-008 rx_valid  output  1  byte available in the holding register.
REQ-009 rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready on a clk edge.
REQ-010 frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-011 overrun  output  1  one-cycle pulse when a new byte completes while rx_valid=1.
REQ-012 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 RsRx passes through a 2-flop synchronizer, reset value 1, before any use.
REQ-014 A tick pulse is generated every DIV = CLK_HZ/(BAUD*OVS) clocks, integer-truncated (27 at defaults); the divider free-runs and restarts at 0 on a start-edge detect.
REQ-015 FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE -> START on a synchronized high-to-low edge; the tick count is cleared.
REQ-017 START: at tick OVS/2-1 (mid-bit), line low -> DATA with the tick count cleared; line high -> IDLE (glitch rejected, no output).
REQ-018 DATA: samples the line every OVS ticks at mid-bit into a shift register LSB first; after the 8th sample -> STOP.
REQ-019 STOP: at mid-bit, line high -> load the holding register and return to IDLE; line low -> pulse frame_err, discard the byte, and go to IDLE only after the line returns high.
REQ-020 Holding register: rx_valid sets on load and clears on handshake; handshake and load in the same cycle leave rx_valid=1 with the new data.
REQ-021 Load while rx_valid=1 and rx_ready=0: the new byte overwrites rx_data and overrun pulses for one cycle.
REQ-022 rx_data changes only on load.
REQ-023 Latency: rx_valid rises within DIV+1 clocks of the stop-bit mid-sample tick.
REQ-024 The receiver accepts back-to-back frames, with a new start edge detected in IDLE immediately after the stop-bit sample.

Reset
REQ-025 While btnCpuReset=0, the block asynchronously forces: FSM IDLE, divider and counters 0, synchronizer 1, rx_data 8'h00, rx_valid 0, frame_err 0, overrun 0, busy 0.
REQ-026 Reset mid-frame discards the partial byte; after release, the block waits for a fresh falling edge and does not resynchronize into the current frame.

Structure
REQ-027 A shared package uart_pkg holds the FSM state enum, the 8N1 frame constants, and the divisor function used by a future uart_tx.
REQ-028 One sub-module, uart_baud_tick (divider with synchronous restart), is instantiated once; uart_tx reuses it.

Verification
REQ-029 Use the defaults at a 20 ns clk period (bit = 432 clk); send 8'hA5 with a valid stop bit and rx_ready=1 -> rx_valid pulses once, rx_data=8'hA5, frame_err=0.
REQ-030 Send 8'h3C then 8'hC3 back-to-back with rx_ready=0 -> after the first frame rx_data=8'h3C, after the second rx_data=8'hC3, rx_valid=1, and overrun pulses exactly once.
REQ-031 Send 8'h55 with a low stop bit held for 2 bit times -> frame_err pulses once, rx_valid stays 0, and the next good frame 8'h01 is received correctly.
REQ-032 A 100 ns low glitch on idle RsRx -> no rx_valid, busy returns to 0 within 1 bit time.
REQ-033 Assert btnCpuReset low during data bit 4 of 8'hFF, release it, then send 8'h0F -> only 8'h0F is delivered.
REQ-034 Hold rx_ready=0 for 1000 clk after rx_valid -> rx_data is stable throughout; rx_ready=1 -> rx_valid clears on the next edge.

Source files
------------

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared UART definitions: receive/transmit FSM states, 8N1 frame shape, baud divisor.
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uartState_t;

   localparam int   DATA_BITS  = 8;
   localparam int   STOP_BITS  = 1;
   localparam logic IDLE_LEVEL = 1'b1;

   // Clocks per oversample tick, truncated toward zero.
   function automatic int baudDiv(input int clkHz, input int baud, input int ovs);
      return clkHz / (baud * ovs);
   endfunction
endpackage

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
// Free-running divider: one-clock tick every DIV clocks, restart returns the count to 0.
// No backpressure; tick is combinational from the count.
module uart_baud_tick #(
   parameter int DIV = 27
) (
   input  logic clk,
   input  logic rstN,
   input  logic restart,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN)
         cnt <= '0;
      else if (restart || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == LAST) && !restart;
endmodule

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// 8N1 UART receiver with a one-byte holding register; rx_valid rises one clock after the stop sample.
// Backpressure: an unaccepted byte is overwritten by the next one and overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 115200,
   parameter int OVS    = 16
) (
   input  logic       clk,
   input  logic       btnCpuReset,
   input  logic       RsRx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);
   localparam int DIV = baudDiv(CLK_HZ, BAUD, OVS);
   localparam int TW  = $clog2(OVS);
   localparam int BW  = $clog2(DATA_BITS);
   localparam logic [TW-1:0] MID_TICK = TW'(OVS / 2 - 1);
   localparam logic [TW-1:0] BIT_TICK = TW'(OVS - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   uartState_t          state, stateNext;
   logic [TW-1:0]       tickCnt, tickCntNext;
   logic [BW-1:0]       bitCnt, bitCntNext;
   logic [7:0]          shiftReg, shiftNext;
   logic                errWait, errWaitNext;
   logic                rxMeta, rxSync, rxPrev;
   logic                fallEdge, tick, restart, load, frameErrSet;

   always_ff @(posedge clk or negedge btnCpuReset) begin
      if (!btnCpuReset) begin
         rxMeta <= IDLE_LEVEL;
         rxSync <= IDLE_LEVEL;
         rxPrev <= IDLE_LEVEL;
      end else begin
         rxMeta <= RsRx;
         rxSync <= rxMeta;
         rxPrev <= rxSync;
      end
   end

   assign fallEdge = rxPrev & ~rxSync;

   uart_baud_tick #(.DIV(DIV)) baudTick (
      .clk     (clk),
      .rstN    (btnCpuReset),
      .restart (restart),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge btnCpuReset) begin
      if (!btnCpuReset) begin
         state    <= IDLE;
         tickCnt  <= '0;
         bitCnt   <= '0;
         shiftReg <= '0;
         errWait  <= 1'b0;
      end else begin
         state    <= stateNext;
         tickCnt  <= tickCntNext;
         bitCnt   <= bitCntNext;
         shiftReg <= shiftNext;
         errWait  <= errWaitNext;
      end
   end

   always_comb begin
      stateNext   = state;
      tickCntNext = tickCnt;
      bitCntNext  = bitCnt;
      shiftNext   = shiftReg;
      errWaitNext = errWait;
      restart     = 1'b0;
      load        = 1'b0;
      frameErrSet = 1'b0;
      case (state)
         IDLE: begin
            if (fallEdge) begin
               stateNext   = START;
               tickCntNext = '0;
               restart     = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               if (tickCnt == MID_TICK) begin
                  tickCntNext = '0;
                  bitCntNext  = '0;
                  stateNext   = rxSync ? IDLE : DATA;
               end else begin
                  tickCntNext = tickCnt + 1'b1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (tickCnt == BIT_TICK) begin
                  tickCntNext = '0;
                  shiftNext   = {rxSync, shiftReg[7:1]};
                  bitCntNext  = bitCnt + 1'b1;
                  if (bitCnt == LAST_BIT)
                     stateNext = STOP;
               end else begin
                  tickCntNext = tickCnt + 1'b1;
               end
            end
         end
         STOP: begin
            // A bad stop bit parks here until the line idles, so a long break is not taken as a start.
            if (errWait) begin
               if (rxSync) begin
                  errWaitNext = 1'b0;
                  stateNext   = IDLE;
               end
            end else if (tick) begin
               if (tickCnt == BIT_TICK) begin
                  tickCntNext = '0;
                  if (rxSync) begin
                     load      = 1'b1;
                     stateNext = IDLE;
                  end else begin
                     frameErrSet = 1'b1;
                     errWaitNext = 1'b1;
                  end
               end else begin
                  tickCntNext = tickCnt + 1'b1;
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge btnCpuReset) begin
      if (!btnCpuReset) begin
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= frameErrSet;
         overrun   <= load & rx_valid & ~rx_ready;
         if (load) begin
            rx_data  <= shiftReg;
            rx_valid <= 1'b1;
         end else if (rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Directed bench for uart_rx at default parameters (20 ns clock, 432 clocks per bit).
module tb_uart_rx;
   localparam int BITCLK = 432;

   logic       clk = 1'b0;
   logic       btnCpuReset = 1'b0;
   logic       RsRx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b1;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int errors = 0;
   int checks = 0;

   int         validRises = 0;
   int         ferrCnt = 0;
   int         ovrCnt = 0;
   logic [7:0] lastData = 8'h00;
   logic       validPrev = 1'b0;

   uart_rx dut (
      .clk         (clk),
      .btnCpuReset (btnCpuReset),
      .RsRx        (RsRx),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .busy        (busy)
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid && !validPrev) begin
         validRises <= validRises + 1;
         lastData   <= rx_data;
      end
      validPrev <= rx_valid;
      if (frame_err) ferrCnt <= ferrCnt + 1;
      if (overrun)   ovrCnt  <= ovrCnt + 1;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] data;
      logic       stopGood;
      logic [7:0] expData;
      int         expRises;
      int         expFerr;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic sendBit(input logic b, input int nBits);
      RsRx = b;
      repeat (nBits * BITCLK) @(negedge clk);
   endtask

   task automatic sendFrame(input logic [7:0] d, input logic stopGood);
      sendBit(1'b0, 1);
      for (int i = 0; i < 8; i++) sendBit(d[i], 1);
      if (stopGood) begin
         sendBit(1'b1, 1);
      end else begin
         sendBit(1'b0, 2);
         RsRx = 1'b1;
      end
   endtask

   initial begin
      int r0, f0, o0, changes;

      vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
      vecs[1] = '{8'h55, 1'b0, 8'hA5, 0, 1};
      vecs[2] = '{8'h01, 1'b1, 8'h01, 1, 0};
      vecs[3] = '{8'h00, 1'b1, 8'h00, 1, 0};
      vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
      vecs[5] = '{8'h80, 1'b1, 8'h80, 1, 0};

      repeat (3) @(negedge clk);
      check("reset rx_valid", rx_valid, 0);
      check("reset rx_data", rx_data, 8'h00);
      check("reset frame_err", frame_err, 0);
      check("reset overrun", overrun, 0);
      check("reset busy", busy, 0);
      btnCpuReset = 1'b1;
      repeat (10) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         r0 = validRises; f0 = ferrCnt; o0 = ovrCnt;
         sendFrame(vecs[i].data, vecs[i].stopGood);
         repeat (100) @(negedge clk);
         check($sformatf("v%0d rises", i), validRises - r0, vecs[i].expRises);
         check($sformatf("v%0d frame_err", i), ferrCnt - f0, vecs[i].expFerr);
         check($sformatf("v%0d overrun", i), ovrCnt - o0, 0);
         check($sformatf("v%0d rx_data", i), rx_data, vecs[i].expData);
         check($sformatf("v%0d rx_valid", i), rx_valid, 0);
         check($sformatf("v%0d busy", i), busy, 0);
         if (vecs[i].expRises != 0)
            check($sformatf("v%0d data at rise", i), lastData, vecs[i].expData);
      end

      // Back-to-back frames with the consumer stalled.
      rx_ready = 1'b0;
      r0 = validRises; o0 = ovrCnt;
      sendFrame(8'h3C, 1'b1);
      check("b2b first data", rx_data, 8'h3C);
      check("b2b first valid", rx_valid, 1);
      sendFrame(8'hC3, 1'b1);
      repeat (20) @(negedge clk);
      check("b2b second data", rx_data, 8'hC3);
      check("b2b second valid", rx_valid, 1);
      check("b2b overrun count", ovrCnt - o0, 1);
      check("b2b valid rises", validRises - r0, 1);

      // Stalled consumer: data must hold, then clear one edge after ready.
      changes = 0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (rx_data !== 8'hC3 || rx_valid !== 1'b1) changes++;
      end
      check("hold stable", changes, 0);
      rx_ready = 1'b1;
      @(negedge clk);
      check("ready clears valid", rx_valid, 0);
      check("ready keeps data", rx_data, 8'hC3);

      // 100 ns glitch on the idle line.
      r0 = validRises; f0 = ferrCnt;
      RsRx = 1'b0;
      repeat (5) @(negedge clk);
      RsRx = 1'b1;
      repeat (20) @(negedge clk);
      check("glitch busy rises", busy, 1);
      repeat (BITCLK) @(negedge clk);
      check("glitch busy back", busy, 0);
      check("glitch no valid", validRises - r0, 0);
      check("glitch no frame_err", ferrCnt - f0, 0);

      // Reset during data bit 4 of 8'hFF, then a clean 8'h0F.
      r0 = validRises;
      sendBit(1'b0, 1);
      for (int i = 0; i < 4; i++) sendBit(1'b1, 1);
      RsRx = 1'b1;
      repeat (200) @(negedge clk);
      check("pre-reset busy", busy, 1);
      btnCpuReset = 1'b0;
      repeat (3) @(negedge clk);
      check("mid-reset busy", busy, 0);
      check("mid-reset rx_data", rx_data, 8'h00);
      check("mid-reset rx_valid", rx_valid, 0);
      btnCpuReset = 1'b1;
      repeat (BITCLK - 203) @(negedge clk);
      sendBit(1'b1, 4);
      repeat (100) @(negedge clk);
      check("reset frame dropped", validRises - r0, 0);
      sendFrame(8'h0F, 1'b1);
      repeat (100) @(negedge clk);
      check("post-reset rises", validRises - r0, 1);
      check("post-reset data", lastData, 8'h0F);
      check("post-reset rx_data", rx_data, 8'h0F);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
